// File: rtl/fsqrt_issue_ctrl_pkg.sv
// Shared constants and types for the FSQRT.S issue/retire sequencer.
// FP32 encodings, fflags bit positions, FSM states and operand classes.
package fsqrt_issue_ctrl_pkg;
    localparam logic [31:0] CANON_NAN = 32'h7FC00000;
    localparam logic [31:0] POS_INF   = 32'h7F800000;

    localparam int FF_NV = 4;
    localparam int FF_DZ = 3;
    localparam int FF_OF = 2;
    localparam int FF_UF = 1;
    localparam int FF_NX = 0;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    typedef enum logic [2:0] {
        CLS_SNAN = 3'd0,
        CLS_QNAN = 3'd1,
        CLS_ZERO = 3'd2,
        CLS_NEG  = 3'd3,
        CLS_PINF = 3'd4,
        CLS_PSUB = 3'd5,
        CLS_NORM = 3'd6
    } cls_t;
endpackage

// File: rtl/fsqrt_issue_ctrl_if.sv
// Request/response handshake bundle between decode/EX and the fsqrt sequencer.
// master = EX/writeback side, slave = sequencer.
interface fsqrt_issue_ctrl_if #(parameter int DW = 32);
    logic          req_valid;
    logic          req_ready;
    logic [DW-1:0] req_a;
    logic [4:0]    req_rd;
    logic          rsp_valid;
    logic          rsp_ready;
    logic [DW-1:0] rsp_y;
    logic [4:0]    rsp_rd;
    logic [4:0]    rsp_fflags;

    modport master (
        output req_valid, req_a, req_rd, rsp_ready,
        input  req_ready, rsp_valid, rsp_y, rsp_rd, rsp_fflags
    );
    modport slave (
        input  req_valid, req_a, req_rd, rsp_ready,
        output req_ready, rsp_valid, rsp_y, rsp_rd, rsp_fflags
    );
endinterface

// File: rtl/fsqrt_issue_ctrl_classify.sv
// Combinational FP32 field classifier used to resolve IEEE special cases at accept time.
module fp32_classify #(
    parameter int DW = 32
) (
    input  logic [DW-1:0] i_a,
    output logic          o_is_snan,
    output logic          o_is_qnan,
    output logic          o_is_zero,
    output logic          o_is_inf,
    output logic          o_is_sub,
    output logic          o_sign
);
    logic [7:0]  w_exp;
    logic [22:0] w_man;

    assign w_exp     = i_a[30:23];
    assign w_man     = i_a[22:0];
    assign o_sign    = i_a[31];
    assign o_is_snan = (w_exp == 8'hFF) && (w_man != '0) && !w_man[22];
    assign o_is_qnan = (w_exp == 8'hFF) && w_man[22];
    assign o_is_inf  = (w_exp == 8'hFF) && (w_man == '0);
    assign o_is_zero = (w_exp == 8'h00) && (w_man == '0);
    assign o_is_sub  = (w_exp == 8'h00) && (w_man != '0);
endmodule

// File: rtl/fsqrt_issue_ctrl.sv
// FSQRT.S issue/retire sequencer: resolves special operands locally, launches the
// iterative core otherwise, guards it with a watchdog and holds the result for writeback.
module fsqrt_issue_ctrl
    import fsqrt_issue_ctrl_pkg::*;
#(
    parameter int DW      = 32,
    parameter int TIMEOUT = 64,
    parameter bit FTZ     = 1'b1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_flush,
    fsqrt_issue_ctrl_if.slave bus,
    output logic              o_busy,
    output logic              o_timeout_err,
    output logic              o_core_enable,
    output logic [DW-1:0]     o_core_a,
    input  logic              i_core_complete,
    input  logic [DW-1:0]     i_core_y
);
    localparam int CW = $clog2(TIMEOUT + 1);

    state_t        r_state, w_nstate;
    logic [DW-1:0] r_y, r_a;
    logic [4:0]    r_rd, r_ff;
    logic [CW-1:0] r_cnt;
    logic          r_tmo;

    logic          w_snan, w_qnan, w_zero, w_inf, w_sub, w_sign;
    cls_t          w_cls;
    logic [DW-1:0] w_spec_y;
    logic [4:0]    w_spec_ff;
    logic          w_accept, w_special, w_expire;

    fp32_classify #(.DW(DW)) u_cls (
        .i_a       (bus.req_a),
        .o_is_snan (w_snan),
        .o_is_qnan (w_qnan),
        .o_is_zero (w_zero),
        .o_is_inf  (w_inf),
        .o_is_sub  (w_sub),
        .o_sign    (w_sign)
    );

    // NaN checks come before the sign test so a negative NaN is still a NaN.
    always_comb begin
        w_cls = CLS_NORM;
        if (w_snan)             w_cls = CLS_SNAN;
        else if (w_qnan)        w_cls = CLS_QNAN;
        else if (w_zero)        w_cls = CLS_ZERO;
        else if (w_sign)        w_cls = CLS_NEG;
        else if (w_inf)         w_cls = CLS_PINF;
        else if (w_sub && FTZ)  w_cls = CLS_PSUB;
    end

    always_comb begin
        w_spec_y  = CANON_NAN;
        w_spec_ff = '0;
        case (w_cls)
            CLS_SNAN: w_spec_ff[FF_NV] = 1'b1;
            CLS_ZERO: w_spec_y = bus.req_a;
            CLS_NEG:  w_spec_ff[FF_NV] = 1'b1;
            CLS_PINF: w_spec_y = POS_INF;
            CLS_PSUB: begin
                w_spec_y         = '0;
                w_spec_ff[FF_NX] = 1'b1;
            end
            default: ;
        endcase
    end

    assign w_special = (w_cls != CLS_NORM);
    assign w_accept  = bus.req_valid && bus.req_ready;
    assign w_expire  = (r_cnt == CW'(TIMEOUT - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= ST_IDLE;
        else        r_state <= w_nstate;
    end

    always_comb begin
        w_nstate = r_state;
        case (r_state)
            ST_IDLE: if (w_accept) w_nstate = w_special ? ST_DONE : ST_RUN;
            ST_RUN: begin
                if (i_flush)                           w_nstate = ST_IDLE;
                else if (i_core_complete || w_expire)  w_nstate = ST_DONE;
            end
            ST_DONE: if (i_flush || bus.rsp_ready) w_nstate = ST_IDLE;
            default: w_nstate = ST_IDLE;
        endcase
    end

    // Complete is tested before expiry, so a late core still wins the tie.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_y   <= '0;
            r_a   <= '0;
            r_rd  <= '0;
            r_ff  <= '0;
            r_cnt <= '0;
            r_tmo <= 1'b0;
        end else if (r_state == ST_IDLE) begin
            if (w_accept) begin
                r_rd <= bus.req_rd;
                if (w_special) begin
                    r_y  <= w_spec_y;
                    r_ff <= w_spec_ff;
                end else begin
                    r_a   <= bus.req_a;
                    r_cnt <= '0;
                end
            end
        end else if (r_state == ST_RUN && !i_flush) begin
            r_cnt <= r_cnt + 1'b1;
            if (i_core_complete) begin
                r_y  <= i_core_y;
                r_ff <= '0;
            end else if (w_expire) begin
                r_y         <= CANON_NAN;
                r_ff        <= '0;
                r_ff[FF_NV] <= 1'b1;
                r_tmo       <= 1'b1;
            end
        end
    end

    assign bus.req_ready  = (r_state == ST_IDLE) && !i_flush;
    assign bus.rsp_valid  = (r_state == ST_DONE);
    assign bus.rsp_y      = r_y;
    assign bus.rsp_rd     = r_rd;
    assign bus.rsp_fflags = r_ff;
    assign o_busy         = (r_state != ST_IDLE);
    assign o_core_enable  = (r_state == ST_RUN);
    assign o_core_a       = r_a;
    assign o_timeout_err  = r_tmo;
endmodule

// File: tb/tb_fsqrt_issue_ctrl.sv
// Scoreboard bench for fsqrt_issue_ctrl with a behavioural fixed-latency sqrt core.
module tb_fsqrt_issue_ctrl;
    localparam int TIMEOUT  = 16;
    localparam int CORE_LAT = 5;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        flush = 1'b0;
    logic        busy, tmo_err, core_en, core_cmp;
    logic [31:0] core_a, core_y;

    logic        stub = 1'b0;
    int          lat_cfg = CORE_LAT;
    int          ccnt;
    int          n_chk = 0;
    int          n_fail = 0;

    typedef struct {
        logic [31:0] y;
        logic [4:0]  rd;
        logic [4:0]  ff;
    } exp_t;
    exp_t sb[$];

    fsqrt_issue_ctrl_if #(.DW(32)) bus ();

    fsqrt_issue_ctrl #(.DW(32), .TIMEOUT(TIMEOUT), .FTZ(1'b1)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .i_flush         (flush),
        .bus             (bus),
        .o_busy          (busy),
        .o_timeout_err   (tmo_err),
        .o_core_enable   (core_en),
        .o_core_a        (core_a),
        .i_core_complete (core_cmp),
        .i_core_y        (core_y)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] core_sqrt(input logic [31:0] a);
        case (a)
            32'h40800000: return 32'h40000000;
            32'h41100000: return 32'h40400000;
            32'h3F800000: return 32'h3F800000;
            32'h40100000: return 32'h3FC00000;
            default:      return 32'hDEADBEEF;
        endcase
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n)       ccnt <= 0;
        else if (!core_en) ccnt <= 0;
        else              ccnt <= ccnt + 1;
    end
    assign core_cmp = core_en && !stub && (ccnt == lat_cfg - 1);
    assign core_y   = core_sqrt(core_a);

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%08h exp=%08h t=%0t", tag, got, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n && bus.rsp_valid && bus.rsp_ready && !flush) begin
            if (sb.size() == 0) begin
                chk("rsp_unexpected", 32'(bus.rsp_valid), 32'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("rsp_y", bus.rsp_y, e.y);
                chk("rsp_rd", 32'(bus.rsp_rd), 32'(e.rd));
                chk("rsp_ff", 32'(bus.rsp_fflags), 32'(e.ff));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [31:0] a, input logic [4:0] rd);
        int n;
        n = 0;
        bus.req_valid = 1'b1;
        bus.req_a     = a;
        bus.req_rd    = rd;
        @(negedge clk);
        while (!bus.req_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) chk("req_ready_wait", 32'(bus.req_ready), 32'd1);
        tick();
        bus.req_valid = 1'b0;
    endtask

    // n = negedges from the accept edge to first rsp_valid; en = RUN cycles seen.
    task automatic run_op(input logic [31:0] a, input logic [4:0] rd, input logic [31:0] y,
                          input logic [4:0] ff, output int n, output int en);
        logic ok_busy, ok_a;
        ok_busy = 1'b1;
        ok_a    = 1'b1;
        sb.push_back('{y, rd, ff});
        send(a, rd);
        n  = 0;
        en = 0;
        while (n < 400) begin
            @(negedge clk);
            n++;
            if (!busy) ok_busy = 1'b0;
            if (core_en) begin
                en++;
                if (core_a !== a) ok_a = 1'b0;
            end
            if (bus.rsp_valid) break;
        end
        chk("rsp_seen", 32'(bus.rsp_valid), 32'd1);
        chk("busy_hold", 32'(ok_busy), 32'd1);
        chk("core_a_stable", 32'(ok_a), 32'd1);
    endtask

    typedef struct {
        logic [31:0] a;
        logic [31:0] y;
        logic [4:0]  ff;
    } spec_t;
    spec_t specs[9] = '{
        '{32'hC0800000, 32'h7FC00000, 5'b10000},
        '{32'h80000000, 32'h80000000, 5'b00000},
        '{32'h7F800001, 32'h7FC00000, 5'b10000},
        '{32'h7FC00000, 32'h7FC00000, 5'b00000},
        '{32'h7F800000, 32'h7F800000, 5'b00000},
        '{32'h00000001, 32'h00000000, 5'b00001},
        '{32'h80000001, 32'h7FC00000, 5'b10000},
        '{32'hFF800000, 32'h7FC00000, 5'b10000},
        '{32'hFFC00000, 32'h7FC00000, 5'b00000}
    };

    initial begin
        #400000;
        $display("FAIL global_timeout");
        $fatal(1, "bench time limit");
    end

    initial begin
        int n, en;
        bus.req_valid = 1'b0;
        bus.req_a     = '0;
        bus.req_rd    = '0;
        bus.rsp_ready = 1'b1;
        #2 rst_n = 1'b0;
        #10;
        chk("rst_req_ready", 32'(bus.req_ready), 32'd1);
        chk("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        chk("rst_rsp_y", bus.rsp_y, 32'd0);
        chk("rst_rsp_rd", 32'(bus.rsp_rd), 32'd0);
        chk("rst_rsp_ff", 32'(bus.rsp_fflags), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_core_en", 32'(core_en), 32'd0);
        chk("rst_core_a", core_a, 32'd0);
        chk("rst_tmo", 32'(tmo_err), 32'd0);
        tick();
        rst_n = 1'b1;
        tick();

        // ordinary operand through the core
        run_op(32'h40800000, 5'd1, 32'h40000000, 5'b0, n, en);
        chk("t1_latency", 32'(n + 1), 32'(CORE_LAT + 2));
        chk("t1_run_cycles", 32'(en), 32'(CORE_LAT));
        tick();

        foreach (specs[i]) begin
            run_op(specs[i].a, 5'(i + 2), specs[i].y, specs[i].ff, n, en);
            chk("spec_latency", 32'(n), 32'd1);
            chk("spec_no_core", 32'(en), 32'd0);
            tick();
        end

        // backpressure holds the result
        bus.rsp_ready = 1'b0;
        run_op(32'h41100000, 5'd20, 32'h40400000, 5'b0, n, en);
        for (int k = 0; k < 10; k++) begin
            tick();
            @(negedge clk);
            chk("bp_valid", 32'(bus.rsp_valid), 32'd1);
            chk("bp_y", bus.rsp_y, 32'h40400000);
            chk("bp_req_ready", 32'(bus.req_ready), 32'd0);
        end
        tick();
        bus.rsp_ready = 1'b1;
        tick();
        @(negedge clk);
        chk("bp_release_ready", 32'(bus.req_ready), 32'd1);
        chk("bp_release_valid", 32'(bus.rsp_valid), 32'd0);

        // flush in IDLE only blocks acceptance
        tick();
        flush = 1'b1;
        @(negedge clk);
        chk("flush_idle_ready", 32'(bus.req_ready), 32'd0);
        tick();
        flush = 1'b0;

        // flush two cycles into RUN
        send(32'h40800000, 5'd21);
        tick();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        @(negedge clk);
        chk("flush_run_busy", 32'(busy), 32'd0);
        chk("flush_run_valid", 32'(bus.rsp_valid), 32'd0);
        chk("flush_run_core_en", 32'(core_en), 32'd0);
        repeat (CORE_LAT + 3) tick();
        run_op(32'h3F800000, 5'd22, 32'h3F800000, 5'b0, n, en);
        tick();

        // flush in DONE with rsp_ready in the same cycle discards
        bus.rsp_ready = 1'b0;
        send(32'hC0800000, 5'd23);
        @(negedge clk);
        chk("flush_done_pre", 32'(bus.rsp_valid), 32'd1);
        tick();
        flush = 1'b1;
        bus.rsp_ready = 1'b1;
        tick();
        flush = 1'b0;
        @(negedge clk);
        chk("flush_done_valid", 32'(bus.rsp_valid), 32'd0);
        chk("flush_done_busy", 32'(busy), 32'd0);
        tick();

        // core completes in the very cycle the watchdog expires
        lat_cfg = TIMEOUT;
        run_op(32'h40100000, 5'd24, 32'h3FC00000, 5'b0, n, en);
        chk("tie_latency", 32'(n), 32'(TIMEOUT + 1));
        chk("tie_tmo", 32'(tmo_err), 32'd0);
        lat_cfg = CORE_LAT;
        tick();

        // watchdog expiry with a dead core
        stub = 1'b1;
        run_op(32'h40800000, 5'd25, 32'h7FC00000, 5'b10000, n, en);
        chk("wd_latency", 32'(n), 32'(TIMEOUT + 1));
        chk("wd_run_cycles", 32'(en), 32'(TIMEOUT));
        chk("wd_tmo_set", 32'(tmo_err), 32'd1);
        tick();
        stub = 1'b0;
        run_op(32'h3F800000, 5'd26, 32'h3F800000, 5'b0, n, en);
        chk("wd_tmo_sticky", 32'(tmo_err), 32'd1);
        tick();

        // async reset mid-RUN
        send(32'h40800000, 5'd27);
        tick();
        #2 rst_n = 1'b0;
        #1;
        chk("arst_core_en", 32'(core_en), 32'd0);
        chk("arst_busy", 32'(busy), 32'd0);
        chk("arst_valid", 32'(bus.rsp_valid), 32'd0);
        chk("arst_ready", 32'(bus.req_ready), 32'd1);
        chk("arst_core_a", core_a, 32'd0);
        chk("arst_rsp_y", bus.rsp_y, 32'd0);
        chk("arst_tmo", 32'(tmo_err), 32'd0);
        tick();
        rst_n = 1'b1;
        tick();
        run_op(32'h41100000, 5'd28, 32'h40400000, 5'b0, n, en);
        chk("arst_fresh_lat", 32'(n + 1), 32'(CORE_LAT + 2));
        tick();
        repeat (3) tick();

        chk("sb_drained", 32'(sb.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end
endmodule
